// File: rtl/hdmi_tmds_encoder.sv
// hdmi_tmds_encoder
//   Two-stage TMDS 8b/10b encoder for one HDMI lane (DVI-style: video data,
//   control tokens and video guard band).
//   Stage 1 transition-minimises the pixel byte into q_m and registers the
//   period type alongside it. Stage 2 DC-balances q_m against the running
//   disparity, or emits a control or guard token and clears the disparity.
//
// Parameters
//   CHANNEL      lane index (0 blue, 1 green, 2 red); selects the guard token
// Ports
//   clk_i        pixel clock
//   rst_i        asynchronous active-high reset
//   data_i[7:0]  pixel component, meaningful when de_i=1
//   de_i         video data period
//   ctrl_i[1:0]  control bits {C1,C0}, used when de_i=0 and gb_i=0
//   gb_i         video guard-band period (has priority over de_i)
//   tmds_o[9:0]  encoded symbol, bit 0 serialised first; 2-cycle latency
//   disparity_o  signed running disparity after the symbol now on tmds_o
module hdmi_tmds_encoder #(
  parameter int CHANNEL = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        data_i,
  input  logic              de_i,
  input  logic [1:0]        ctrl_i,
  input  logic              gb_i,
  output logic [9:0]        tmds_o,
  output logic signed [5:0] disparity_o
);

  typedef enum logic [1:0] {
    PER_CTRL  = 2'd0,
    PER_DATA  = 2'd1,
    PER_GUARD = 2'd2
  } period_t;

  localparam logic [9:0] CTRL_00  = 10'b1101010100;
  localparam logic [9:0] CTRL_01  = 10'b0010101011;
  localparam logic [9:0] CTRL_10  = 10'b0101010100;
  localparam logic [9:0] CTRL_11  = 10'b1010101011;
  localparam logic [9:0] GUARD_TK = (CHANNEL == 1) ? 10'b0100110011
                                                   : 10'b1011001100;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  // ---------------- stage 1: transition minimisation ----------------
  logic [3:0] n1_in;
  logic       use_xnor;
  logic [8:0] q_m_next;
  period_t    period_next;

  always_comb begin
    n1_in    = ones8(data_i);
    use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !data_i[0]);
    q_m_next = '0;
    q_m_next[0] = data_i[0];
    for (int unsigned i = 1; i < 8; i++)
      q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ data_i[i])
                             :  (q_m_next[i-1] ^ data_i[i]);
    q_m_next[8] = ~use_xnor;
    // guard band wins over video data, video data over control
    if (gb_i)      period_next = PER_GUARD;
    else if (de_i) period_next = PER_DATA;
    else           period_next = PER_CTRL;
  end

  period_t    period_q;
  logic [1:0] ctrl_q;
  logic [8:0] q_m_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_q <= PER_CTRL;
      ctrl_q   <= '0;
      q_m_q    <= '0;
    end else begin
      period_q <= period_next;
      ctrl_q   <= ctrl_i;
      q_m_q    <= q_m_next;
    end
  end

  // ---------------- stage 2: DC balance / token insertion ----------------
  logic [3:0] n1;
  logic [3:0] n0;
  logic [5:0] diff;     // n1 - n0, two's complement
  logic [5:0] cnt;
  logic       cnt_pos;
  logic       cnt_neg;
  logic [9:0] tmds_next;
  logic [5:0] cnt_next;

  always_comb begin
    n1        = ones8(q_m_q[7:0]);
    n0        = 4'd8 - n1;
    diff      = 6'(n1) - 6'(n0);
    cnt       = disparity_o;
    cnt_pos   = !cnt[5] && (cnt != '0);
    cnt_neg   = cnt[5];
    tmds_next = CTRL_00;
    cnt_next  = '0;
    unique case (period_q)
      PER_DATA: begin
        if ((cnt == '0) || (n1 == n0)) begin
          tmds_next = {~q_m_q[8], q_m_q[8],
                       q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
          cnt_next  = q_m_q[8] ? cnt + diff : cnt - diff;
        end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
          tmds_next = {1'b1, q_m_q[8], ~q_m_q[7:0]};
          cnt_next  = cnt + {4'b0, q_m_q[8], 1'b0} - diff;
        end else begin
          tmds_next = {1'b0, q_m_q[8], q_m_q[7:0]};
          cnt_next  = cnt + diff - {4'b0, ~q_m_q[8], 1'b0};
        end
      end
      PER_GUARD: tmds_next = GUARD_TK;
      default: begin
        unique case (ctrl_q)
          2'b00:   tmds_next = CTRL_00;
          2'b01:   tmds_next = CTRL_01;
          2'b10:   tmds_next = CTRL_10;
          default: tmds_next = CTRL_11;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmds_o      <= CTRL_00;
      disparity_o <= '0;
    end else begin
      tmds_o      <= tmds_next;
      disparity_o <= cnt_next;
    end
  end

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// tb_hdmi_tmds_encoder
//   Directed bench for hdmi_tmds_encoder. Lane 0 and lane 1 instances share
//   the stimulus; lane 1 is only used to see its own guard token.
//   Every step records its own inputs and hand-computed expectation; the
//   symbol appears two edges later and is checked one step afterwards.
//   Besides the hand values, each data symbol is decoded back to its byte and
//   the disparity is tracked from the symbol's ones-count.
module tb_hdmi_tmds_encoder;

  logic              clk;
  logic              rst;
  logic [7:0]        data;
  logic              de;
  logic [1:0]        ctrl;
  logic              gb;
  logic [9:0]        tmds0;
  logic [9:0]        tmds1;
  logic signed [5:0] disp0;
  logic signed [5:0] disp1;

  hdmi_tmds_encoder #(.CHANNEL(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .de_i(de), .ctrl_i(ctrl),
    .gb_i(gb), .tmds_o(tmds0), .disparity_o(disp0)
  );

  hdmi_tmds_encoder #(.CHANNEL(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .de_i(de), .ctrl_i(ctrl),
    .gb_i(gb), .tmds_o(tmds1), .disparity_o(disp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  bit [9:0] ctok [0:3] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  typedef struct {
    bit        valid;
    bit        de;
    bit        gb;
    bit [1:0]  ctrl;
    bit [7:0]  data;
    bit        has_exp;
    bit [9:0]  etmds;
    int        edisp;
    string     tag;
  } rec_t;

  rec_t pend;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h (%0d) expected 0x%0h (%0d)",
             tag, obs, obs, exp, exp);
    end
  endtask

  function automatic bit [7:0] decode(input bit [9:0] s);
    bit [7:0] q;
    bit [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic check_pending();
    int sd;
    int ad;
    if (!pend.valid) return;
    sd = int'(disp0);
    if (pend.has_exp) begin
      chk({pend.tag, "_tmds"}, int'(tmds0), int'(pend.etmds));
      chk({pend.tag, "_disp"}, sd, pend.edisp);
    end
    if (pend.gb) begin
      chk({pend.tag, "_gb0"}, int'(tmds0), 32'h2CC);
      chk({pend.tag, "_gb1"}, int'(tmds1), 32'h133);
      chk({pend.tag, "_gbd"}, sd, 0);
      chk({pend.tag, "_gbd1"}, int'(disp1), 0);
      model_cnt = 0;
    end else if (!pend.de) begin
      chk({pend.tag, "_ctok"}, int'(tmds0), int'(ctok[pend.ctrl]));
      chk({pend.tag, "_cd"}, sd, 0);
      model_cnt = 0;
    end else begin
      chk({pend.tag, "_dec"}, int'(decode(tmds0)), int'(pend.data));
      model_cnt = model_cnt + 2 * $countones(tmds0) - 10;
      chk({pend.tag, "_rd"}, sd, model_cnt);
      ad = (sd < 0) ? -sd : sd;
      chk({pend.tag, "_bound"}, int'(ad <= 10), 1);
    end
  endtask

  task automatic step(input bit de_v, input bit gb_v, input bit [1:0] c,
                      input bit [7:0] d, input bit he, input bit [9:0] et,
                      input int ed, input string tag);
    de = de_v; gb = gb_v; ctrl = c; data = d;
    @(posedge clk);
    #1;
    check_pending();
    pend.valid = 1'b1; pend.de = de_v; pend.gb = gb_v; pend.ctrl = c;
    pend.data = d; pend.has_exp = he; pend.etmds = et; pend.edisp = ed;
    pend.tag = tag;
  endtask

  task automatic set_pend_ctrl00(input string tag);
    pend.valid = 1'b1; pend.de = 1'b0; pend.gb = 1'b0; pend.ctrl = 2'b00;
    pend.data = 8'h00; pend.has_exp = 1'b1; pend.etmds = 10'h354;
    pend.edisp = 0; pend.tag = tag;
  endtask

  initial begin
    pend.valid = 1'b0;
    rst = 1'b1; de = 1'b0; gb = 1'b0; ctrl = 2'b00; data = 8'h00;

    // reset is visible without any clock edge
    #2;
    chk("rst_tmds", int'(tmds0), 32'h354);
    chk("rst_disp", int'(disp0), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel1_tmds", int'(tmds0), 32'h354);
    chk("rel1_disp", int'(disp0), 0);
    set_pend_ctrl00("rel2");
    model_cnt = 0;

    // control tokens, guard band, guard priority over data
    step(0, 0, 2'b00, 8'h00, 1, 10'h354, 0, "c00");
    step(0, 0, 2'b01, 8'h00, 1, 10'h0AB, 0, "c01");
    step(0, 0, 2'b10, 8'h00, 1, 10'h154, 0, "c10");
    step(0, 0, 2'b11, 8'h00, 1, 10'h2AB, 0, "c11");
    step(0, 1, 2'b00, 8'h00, 1, 10'h2CC, 0, "gb");
    step(1, 1, 2'b00, 8'h00, 1, 10'h2CC, 0, "gb_de");

    // 0x00 stream: case A, then alternating B / C, back to 0, case A again
    step(1, 0, 2'b00, 8'h00, 1, 10'h100, -8, "z1_A");
    step(1, 0, 2'b00, 8'h00, 1, 10'h3FF,  2, "z2_B");
    step(1, 0, 2'b00, 8'h00, 1, 10'h100, -6, "z3_C");
    step(1, 0, 2'b00, 8'h00, 1, 10'h3FF,  4, "z4_B");
    step(1, 0, 2'b00, 8'h00, 1, 10'h100, -4, "z5_C");
    step(1, 0, 2'b00, 8'h00, 1, 10'h3FF,  6, "z6_B");
    step(1, 0, 2'b00, 8'h00, 1, 10'h100, -2, "z7_C");
    step(1, 0, 2'b00, 8'h00, 1, 10'h3FF,  8, "z8_B");
    step(1, 0, 2'b00, 8'h00, 1, 10'h100,  0, "z9_C");
    step(1, 0, 2'b00, 8'h00, 1, 10'h100, -8, "z10_A");
    // balanced q_m at nonzero disparity (XOR then XNOR tie-break)
    step(1, 0, 2'b00, 8'h55, 1, 10'h133, -8, "tie55");
    step(1, 0, 2'b00, 8'hAA, 1, 10'h233, -8, "tieAA");
    step(0, 0, 2'b00, 8'h00, 1, 10'h354,  0, "clr");
    step(1, 0, 2'b00, 8'hFF, 1, 10'h200, -8, "ones");
    step(0, 0, 2'b11, 8'h00, 1, 10'h2AB,  0, "clr2");
    step(1, 0, 2'b00, 8'h0F, 1, 10'h105, -4, "x0F");
    step(1, 0, 2'b00, 8'h00, 1, 10'h3FF,  6, "x00B");

    // random traffic, checked by decode / disparity / token properties
    for (int i = 0; i < 3000; i++)
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 9) == 0),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           0, 10'h000, 0, "rnd");

    // reset in the middle of a data burst
    step(1, 0, 2'b00, 8'h00, 0, 10'h000, 0, "pre1");
    step(1, 0, 2'b00, 8'hFF, 0, 10'h000, 0, "pre2");
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tmds", int'(tmds0), 32'h354);
    chk("mid_rst_disp", int'(disp0), 0);
    pend.valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_hold_tmds", int'(tmds0), 32'h354);
    chk("mid_hold_disp", int'(disp0), 0);
    #2;
    rst = 1'b0; de = 1'b0; gb = 1'b0; ctrl = 2'b00; data = 8'h00;
    @(posedge clk);
    #1;
    chk("mid_rel1_tmds", int'(tmds0), 32'h354);
    chk("mid_rel1_disp", int'(disp0), 0);
    set_pend_ctrl00("mid_rel2");
    model_cnt = 0;
    step(1, 0, 2'b00, 8'h00, 1, 10'h100, -8, "first_after_rst");
    step(0, 0, 2'b01, 8'h00, 1, 10'h0AB,  0, "tail");
    step(0, 0, 2'b00, 8'h00, 0, 10'h000,  0, "flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
